data_mem_bank: RTL
==================

// Module: data_mem_bank
// PURPOSE
//  Parametrised single-port data memory for the CPU datapath; next generation of the flat word memory.
//  Adds byte-lane write enables, byte addressing with alignment check, range check and a valid/ready
//  request port. Read latency is configurable. A post-reset clear sweep zeroes one word per cycle.
//  Sits between the load/store unit and the register-file writeback mux.
// PARAMETERS
//  DATA_W    32  data width in bits; multiple of 8
//  DEPTH     32  number of words; need not be a power of 2
//  ADDR_W    32  request byte-address width
//  READ_LAT  1   read latency in cycles from request accept to rsp_valid; legal values 1 or 2
// PORTS
//  clk        in   1         clock; all logic on posedge
//  reset      in   1         synchronous, active-high
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept; low during clear sweep
//  req_we     in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte-lane enables for writes; ignored on reads
//  rsp_valid  out  1         response strobe, one cycle per accepted request (reads and writes)
//  rsp_rdata  out  DATA_W    read data; 0 for writes and errors
//  rsp_err    out  1         request was misaligned or out of range
//  busy       out  1         clear sweep in progress
// BEHAVIOUR
//  - Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM -> CLEAR, sweep ptr=0.
//  - FSM CLEAR: write 0 to word[ptr]; ptr++. When ptr==DEPTH-1 is written -> READY next cycle.
//    Clear takes exactly DEPTH cycles after reset deasserts. busy=1 and req_ready=0 throughout.
//  - FSM READY: req_ready=1, busy=0. Accept = req_valid & req_ready. One request per cycle, no stall.
//  - Word index = req_addr >> log2(DATA_W/8). Misaligned = low log2(DATA_W/8) addr bits != 0.
//    Out of range = word index >= DEPTH. Either condition -> err: no write, rdata 0, rsp_err=1.
//  - Write: for each lane i with req_be[i]=1, byte i of word <= req_wdata byte i; other lanes keep.
//    req_be all zero is a legal no-op write (rsp_valid=1, rsp_err=0).
//  - Read: data sampled from array at accept edge; rsp_valid/rsp_rdata/rsp_err appear READ_LAT
//    cycles after accept edge. Writes also return rsp_valid after READ_LAT (rdata=0), keeping order.
//  - Write then read of same word on consecutive accepted cycles: read returns the new data.
//  - No read-during-write hazard: single request per cycle.
//  - Response outputs are registered; rsp_rdata/rsp_err are 0 when rsp_valid=0.
//  - Reset mid-operation: in-flight responses discarded (rsp_valid=0 next cycle); sweep restarts at 0.
//  - rsp_rdata is never high-Z; no internal tri-states.
// STRUCTURE
//  - Package mem_pkg: READ_LAT legal-value constants, FSM state enum {ST_CLEAR, ST_READY},
//    function clog2 for lane/index width calculation.
//  - One sub-module mem_rsp_pipe: READ_LAT-deep shift register of {valid, err, rdata};
//    synchronous reset clears valid bits. Array, decode, FSM and lane writes stay in the top module.
// TESTING
//  - Reset, DEPTH=32: req_ready low for exactly 32 cycles after reset release; busy falls with it.
//  - Write 0xDEADBEEF to addr 0x8, be=4'hF; read 0x8 -> rsp_valid after READ_LAT, rdata 0xDEADBEEF.
//  - Then write 0x000000AA to 0x8, be=4'b0001; read -> 0xDEADBEAA.
//  - Read addr 0x6 (misaligned) and 0x80 (index 32 >= DEPTH) -> rsp_err=1, rdata 0; memory unchanged.
//  - Back-to-back write 0x11 @0x4 then read @0x4 on the next cycle -> 0x00000011; READ_LAT=2 ordering.
//  - Assert reset with two reads in flight -> no rsp_valid afterwards; read 0x8 after sweep -> 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and width helper for the data memory bank.
package mem_pkg;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Response delay line: LAT stages of {valid, err, rdata}, cleared on reset so
// in-flight responses are dropped.
module mem_rsp_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  input  logic              in_err_i,
  input  logic [DATA_W-1:0] in_rdata_i,
  output logic              out_valid_o,
  output logic              out_err_o,
  output logic [DATA_W-1:0] out_rdata_o
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] err_q;
  logic [DATA_W-1:0] rdata_q [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LAT; i++) rdata_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      err_q[0]   <= in_err_i;
      rdata_q[0] <= in_rdata_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_err_o   = err_q[LAT-1];
  assign out_rdata_o = rdata_q[LAT-1];

endmodule

// File: rtl/data_mem_bank.sv
// Single-port data memory with byte-lane writes, alignment/range checking,
// a post-reset clear sweep and a fixed-latency response pipe.
module data_mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output state_e              dbg_state
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = clog2(NB);
  localparam int PTR_W  = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int LAT    = (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX :
                          (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN : READ_LAT;

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both high; exactly one response follows LAT cycles later.

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [ADDR_W-1:0]  word_idx;
  logic [PTR_W-1:0]   idx;
  logic               misaligned, out_of_range, err, accept, clr_we;
  logic [DATA_W-1:0]  rd_word, pipe_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end
      end
      ST_READY: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_READY);
    busy      = (state_q == ST_CLEAR);
    clr_we    = (state_q == ST_CLEAR);
  end

  assign dbg_state    = state_q;
  assign word_idx     = req_addr >> LANE_W;
  assign misaligned   = (req_addr & ADDR_W'(NB - 1)) != '0;
  assign out_of_range = word_idx >= ADDR_W'(DEPTH);
  assign err          = misaligned | out_of_range;
  assign idx          = word_idx[PTR_W-1:0];
  assign accept       = req_valid & req_ready;
  assign rd_word      = mem_q[idx];

  // The sweep and request writes never overlap: requests are only accepted in READY.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[ptr_q] <= '0;
    end else if (accept && req_we && !err) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign pipe_rdata = (accept && !req_we && !err) ? rd_word : '0;

  mem_rsp_pipe #(
    .DATA_W (DATA_W),
    .LAT    (LAT)
  ) u_rsp_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (accept),
    .in_err_i    (accept & err),
    .in_rdata_i  (pipe_rdata),
    .out_valid_o (rsp_valid),
    .out_err_o   (rsp_err),
    .out_rdata_o (rsp_rdata)
  );

endmodule
